// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer.
// One serial stream of WIDTH-bit beats, framed by a start-of-frame marker,
// fans out to NUM_CH channel registers. Beat k of a frame lands in channel k.
// A two-state HUNT/RUN machine tracks frame alignment and flags framing
// violations on sync_err.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to add an even-parity input
// (in_parity) and a parity-error strobe (par_err). A beat whose parity does
// not match is dropped entirely and has no effect on framing.
//
// Handshake: there is no back-pressure. A beat is taken on every rising edge
// where in_valid is high; in_sof and in_data are ignored when in_valid is low.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [WIDTH-1:0]          in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                      in_parity,
    output logic                      par_err,
`endif
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic [NUM_CH-1:0]         out_valid,
    output logic                      frame_done,
    output logic                      sync_err,
    output logic                      locked
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [SW-1:0] SLOT_ZERO = '0;
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);

    // Frame-alignment states; locked mirrors RUN directly.
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              r_state;
    logic [SW-1:0]           r_slot;
    logic [NUM_CH*WIDTH-1:0] r_out_data;
    logic [NUM_CH-1:0]       r_out_valid;
    logic                    r_frame_done;
    logic                    r_sync_err;
    logic                    r_par_err;

    logic                    w_par_ok;
    logic [NUM_CH-1:0]       w_slot_oh;

`ifdef TDM_DEMUX_PARITY_EN
    // Even parity: in_parity must equal the XOR of all data bits.
    assign w_par_ok = (in_parity == (^in_data));
`else
    assign w_par_ok = 1'b1;
`endif

    // One-hot decode of the current slot, used to select the channel register.
    always_comb begin
        w_slot_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_slot == SW'(c)) begin
                w_slot_oh[c] = 1'b1;
            end
        end
    end

    // Framing state machine, channel registers and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_slot       <= SLOT_ZERO;
            r_out_data   <= '0;
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_par_err    <= 1'b0;
        end else begin
            // Strobes default low; only the branch that fires raises one.
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_par_err    <= 1'b0;

            if (in_valid && !w_par_ok) begin
                // Corrupted beat: no write, no framing effect, slot holds.
                r_par_err <= 1'b1;
            end else if (in_valid) begin
                if (r_state == ST_HUNT) begin
                    // Non-SOF beats are discarded quietly while hunting.
                    if (in_sof) begin
                        r_out_data[0 +: WIDTH] <= in_data;
                        r_out_valid[0]         <= 1'b1;
                        r_slot                 <= SLOT_ONE;
                        r_state                <= ST_RUN;
                    end
                end else begin
                    if (in_sof) begin
                        // SOF always restarts at slot 0; an SOF mid-frame
                        // abandons the partial frame and reports it.
                        if (r_slot != SLOT_ZERO) begin
                            r_sync_err <= 1'b1;
                        end
                        r_out_data[0 +: WIDTH] <= in_data;
                        r_out_valid[0]         <= 1'b1;
                        r_slot                 <= SLOT_ONE;
                    end else if (r_slot == SLOT_ZERO) begin
                        // Expected an SOF here: alignment is lost.
                        r_sync_err <= 1'b1;
                        r_state    <= ST_HUNT;
                    end else begin
                        for (int c = 1; c < NUM_CH; c++) begin
                            if (w_slot_oh[c]) begin
                                r_out_data[c*WIDTH +: WIDTH] <= in_data;
                            end
                        end
                        r_out_valid <= w_slot_oh;
                        if (r_slot == SLOT_LAST) begin
                            r_frame_done <= 1'b1;
                            r_slot       <= SLOT_ZERO;
                        end else begin
                            r_slot <= r_slot + SLOT_ONE;
                        end
                    end
                end
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = (r_state == ST_RUN);
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err    = r_par_err;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and random stimulus for tdm_demux, checked against
// a frame-level reference model (position within frame, lock flag and a
// per-channel array). Define TDM_DEMUX_PARITY_EN to exercise the parity option.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int DW     = NUM_CH * WIDTH;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [WIDTH-1:0]  in_data;
    logic [DW-1:0]     out_data;
    logic [NUM_CH-1:0] out_valid;
    logic              frame_done;
    logic              sync_err;
    logic              locked;
`ifdef TDM_DEMUX_PARITY_EN
    logic              in_parity;
    logic              par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0]  m_ch [NUM_CH];
    bit                m_locked;
    int                m_pos;
    logic [NUM_CH-1:0] e_valid;
    bit                e_fd;
    bit                e_se;
    bit                e_pe;

    tdm_demux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
`ifdef TDM_DEMUX_PARITY_EN
        .in_parity  (in_parity),
        .par_err    (par_err),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: decide what this cycle's inputs should do.
    task automatic model_apply();
        e_valid = '0;
        e_fd    = 1'b0;
        e_se    = 1'b0;
        e_pe    = 1'b0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) m_ch[c] = '0;
            m_locked = 1'b0;
            m_pos    = 0;
            return;
        end
        if (!in_valid) return;
`ifdef TDM_DEMUX_PARITY_EN
        if (in_parity != ($countones(in_data) % 2 == 1)) begin
            e_pe = 1'b1;
            return;
        end
`endif
        if (!m_locked) begin
            if (in_sof) begin
                m_ch[0]  = in_data;
                e_valid  = 1;
                m_pos    = 1;
                m_locked = 1'b1;
            end
        end else if (in_sof) begin
            if (m_pos != 0) e_se = 1'b1;
            m_ch[0] = in_data;
            e_valid = 1;
            m_pos   = 1;
        end else if (m_pos == 0) begin
            e_se     = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_ch[m_pos] = in_data;
            e_valid     = NUM_CH'(1) << m_pos;
            if (m_pos == NUM_CH - 1) begin
                e_fd  = 1'b1;
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] e_data;
        for (int c = 0; c < NUM_CH; c++) e_data[c*WIDTH +: WIDTH] = m_ch[c];
        check("out_data",   64'(out_data),   64'(e_data));
        check("out_valid",  64'(out_valid),  64'(e_valid));
        check("frame_done", 64'(frame_done), 64'(e_fd));
        check("sync_err",   64'(sync_err),   64'(e_se));
        check("locked",     64'(locked),     64'(m_locked));
`ifdef TDM_DEMUX_PARITY_EN
        check("par_err",    64'(par_err),    64'(e_pe));
`endif
    endtask

    // One clock: model predicts, edge fires, outputs checked 1 time unit later.
    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Driver tasks
    task automatic beat(input logic v, input logic sof, input logic [WIDTH-1:0] d);
        rst      = 1'b0;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
        in_parity = ^d;
`endif
        step();
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic beat_bad(input logic sof, input logic [WIDTH-1:0] d);
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_sof    = sof;
        in_data   = d;
        in_parity = ~(^d);
        step();
    endtask
`endif

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, WIDTH'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst      = 1'b1;
            in_valid = 1'(($urandom_range(0, 1)));
            in_sof   = 1'(($urandom_range(0, 1)));
            in_data  = WIDTH'($urandom);
`ifdef TDM_DEMUX_PARITY_EN
            in_parity = 1'($urandom_range(0, 1));
`endif
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
        in_parity = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) m_ch[c] = '0;
        m_locked = 1'b0;
        m_pos    = 0;
        do_reset(2);

        // Reset in the middle of a frame, then a stray non-SOF beat.
        beat(1, 1, 8'h11);
        beat(1, 0, 8'h22);
        do_reset(2);
        check("rst_data",   64'(out_data),  64'h0);
        check("rst_valid",  64'(out_valid), 64'h0);
        check("rst_locked", 64'(locked),    64'h0);
        beat(1, 0, 8'h55);
        check("hunt_drop_serr", 64'(sync_err), 64'h0);

        // Clean back-to-back frame.
        beat(1, 1, 8'h11);
        check("clean_v0",   64'(out_valid), 64'h1);
        check("clean_lock", 64'(locked),    64'h1);
        beat(1, 0, 8'h22);
        check("clean_v1",   64'(out_valid), 64'h2);
        beat(1, 0, 8'h33);
        check("clean_v2",   64'(out_valid), 64'h4);
        beat(1, 0, 8'h44);
        check("clean_v3",   64'(out_valid), 64'h8);
        check("clean_fd",   64'(frame_done), 64'h1);
        check("clean_data", 64'(out_data),  64'h44332211);

        // Gapped frame: two idle cycles after every beat.
        beat(1, 1, 8'h11); idle(2);
        beat(1, 0, 8'h22); idle(2);
        beat(1, 0, 8'h33); idle(2);
        beat(1, 0, 8'h44);
        check("gap_fd",   64'(frame_done), 64'h1);
        check("gap_data", 64'(out_data),   64'h44332211);
        idle(2);

        // Early SOF abandons the first frame.
        beat(1, 1, 8'h11);
        beat(1, 0, 8'h22);
        beat(1, 1, 8'hA0);
        check("early_serr", 64'(sync_err), 64'h1);
        beat(1, 0, 8'hB0);
        beat(1, 0, 8'hC0);
        beat(1, 0, 8'hD0);
        check("early_fd",   64'(frame_done), 64'h1);
        check("early_data", 64'(out_data),   64'hD0C0B0A0);

        // Missing SOF after a complete frame, then relock.
        beat(1, 1, 8'h01); beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);
        beat(1, 0, 8'h99);
        check("miss_serr", 64'(sync_err),  64'h1);
        check("miss_lock", 64'(locked),    64'h0);
        check("miss_data", 64'(out_data),  64'h04030201);
        beat(1, 1, 8'h77);
        check("relock",     64'(locked),   64'h1);
        check("relock_ch0", 64'(out_data), 64'h04030277);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity error on slot 1 holds the slot; a good resend completes.
        beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);
        beat(1, 1, 8'h11);
        beat_bad(0, 8'h22);
        check("par_err",  64'(par_err),   64'h1);
        check("par_hold", 64'(out_valid), 64'h0);
        beat(1, 0, 8'h22);
        check("par_resend", 64'(out_valid), 64'h2);
        beat(1, 0, 8'h33);
        beat(1, 0, 8'h44);
        check("par_fd",   64'(frame_done), 64'h1);
        check("par_data", 64'(out_data),   64'h44332211);
        beat_bad(1, 8'h5A);
        check("par_sof_nosync", 64'(sync_err), 64'h0);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1);
            end else begin
`ifdef TDM_DEMUX_PARITY_EN
                if ($urandom_range(0, 9) == 0) begin
                    beat_bad(1'($urandom_range(0, 1)), WIDTH'($urandom));
                end else
`endif
                begin
                    beat(1'($urandom_range(0, 3) != 0),
                         1'($urandom_range(0, 4) == 0),
                         WIDTH'($urandom));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential time-division demultiplexer; the receive-side counterpart of the mux primitives in the combinational library.
- Accepts one serial stream of WIDTH-bit beats framed by a start-of-frame marker.
- Routes beat k of each frame to output channel k, holding each channel in a register and strobing a per-channel valid.
- Tracks frame alignment with a hunt/run state machine and flags sync errors.

Parameters:
- NUM_CH, 4, number of output channels = slots per frame; legal range >= 2.
- WIDTH, 8, bits per beat/channel.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  beat is slot 0 of a frame; only meaningful with in_valid.
- in_data  input  WIDTH  beat payload.
- out_data  output  NUM_CH*WIDTH  channel registers; channel c at bits [c*WIDTH +: WIDTH].
- out_valid  output  NUM_CH  one-cycle strobe, bit c high when channel c updated.
- frame_done  output  1  one-cycle pulse when slot NUM_CH-1 is written.
- sync_err  output  1  one-cycle pulse on framing violation.
- locked  output  1  high while in RUN state.

Behaviour:
- Reset: on clk edge with rst=1, out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0, state=HUNT, slot=0. Reset mid-frame discards the partial frame; channel registers are zeroed.
- Slot counter width is $clog2(NUM_CH). Counting runs 0..NUM_CH-1 and wraps to 0.
- All outputs are registered. Latency is 1 cycle: a beat accepted at edge n appears on out_data/out_valid after edge n.
- Cycles with in_valid=0 change nothing. All strobes are 0 and slot holds. Gaps between beats are legal anywhere in a frame.
- HUNT state:
  - Beats with in_sof=0 are dropped silently (no sync_err).
  - On in_valid & in_sof: write ch0, strobe out_valid[0], set slot=1, go to RUN.
- RUN state, beat with in_valid=1:
  - slot!=0 & in_sof=0: write ch[slot], strobe out_valid[slot]. If slot==NUM_CH-1, pulse frame_done and wrap slot to 0; else slot+1.
  - slot==0 & in_sof=1: normal frame start. Write ch0, slot=1.
  - slot!=0 & in_sof=1 (early SOF): pulse sync_err. Treat the beat as slot 0: write ch0, set slot=1, stay in RUN. The abandoned frame produces no frame_done.
  - slot==0 & in_sof=0 (missing SOF): pulse sync_err, drop the beat, go to HUNT, locked=0.
- Channels not written in a cycle hold their previous value.
- At most one out_valid bit is high per cycle.
- NUM_CH=2 is legal: every second beat completes a frame.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- With the macro defined:
  - Extra input port in_parity (1 bit) gives even parity over in_data.
  - Extra output par_err (1 bit, reset 0).
  - A beat with a parity mismatch is dropped (no channel write, no strobe, slot unchanged) and par_err pulses for one cycle.
  - A mismatching beat carrying in_sof does not start or resync a frame.
  - State is otherwise unaffected.
- Without the macro: no in_parity/par_err ports, and all beats are accepted as described above.

Test Plan:
- Reset check: hold rst 2 cycles mid-stream -> out_data=0, out_valid=0, locked=0. The next non-SOF beat 0x55 is dropped with no sync_err.
- Clean frame (NUM_CH=4, WIDTH=8): beats 0x11(sof),0x22,0x33,0x44 back-to-back. Expect out_valid=0001,0010,0100,1000 on successive cycles, out_data=0x44332211, frame_done only with the 0x44 update, locked=1 after the first beat.
- Gapped frame: same beats with 2 idle cycles between each. Expect identical out_data and strobes, each 1 cycle after its beat, and no strobes during idle cycles.
- Early SOF: 0x11(sof),0x22, then 0xA0(sof),0xB0,0xC0,0xD0. Expect sync_err pulse with the 0xA0 beat, no frame_done for the first frame, a single frame_done at 0xD0, out_data=0xD0C0B0A0.
- Missing SOF: complete frame, then 0x99 with in_sof=0. Expect sync_err pulse, 0x99 not written, locked=0. A subsequent 0x77(sof) relocks and writes ch0=0x77.
- Parity (macro defined): frame with beat 1 = 0x22 sent with in_parity=1. Expect par_err pulse, ch1 unchanged, slot held at 1. Resending 0x22 with in_parity=0 writes ch1 and the frame completes normally.
